// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences one run of an attached CPU.
// A start pulse holds the CPU in reset for RST_CYCLES cycles and then releases
// it. The run ends on a halt (nxtPC == pc for HALT_REPEAT consecutive cycles,
// alures captured into result) or when MAX_CYCLES RUN cycles elapse (timeout).
// Results hold in DONE until the next start.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            single-cycle pulse that launches a run (IDLE/DONE only)
//   pc, nxtPC        CPU current / next PC, compared for halt detection
//   alures           CPU ALU result, captured at halt
//   cpu_rst          active-high reset to the CPU (low only in RUN)
//   done, timeout    run finished / finished by budget exhaustion
//   cycle_cnt        RUN cycles elapsed (saturating)
//   result           alures captured at halt
//   trace_idx        trace read index, 0 = newest entry
//   trace_pc         trace read data
//
// Optional feature: define CPU_RUN_CTRL_TRACE_EN for a 16-entry PC trace
// buffer; without it trace_pc reads 0 and no storage exists.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned HALT_REPEAT = 3,
  parameter int unsigned MAX_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] nxtPC,
  input  logic [31:0] alures,
  output logic        cpu_rst,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] result,
  input  logic [3:0]  trace_idx,
  output logic [31:0] trace_pc
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rep_q, rep_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        timeout_q, timeout_d;
  logic        trace_we, trace_clr;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    trace_we  = 1'b0;
    trace_clr = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_HOLD;
          hold_d    = '0;
          rep_d     = '0;
          cnt_d     = '0;
          result_d  = '0;
          timeout_d = 1'b0;
          trace_clr = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q + 32'd1 >= 32'(RST_CYCLES)) state_d = S_RUN;
        else                                  hold_d  = hold_q + 32'd1;
      end
      S_RUN: begin
        trace_we = 1'b1;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        rep_d    = (nxtPC == pc) ? rep_q + 32'd1 : '0;
        // Halt is tested first so it wins a same-cycle tie with the budget.
        if (rep_d >= 32'(HALT_REPEAT)) begin
          state_d   = S_DONE;
          result_d  = alures;
          timeout_d = 1'b0;
        end else if (cnt_d >= 32'(MAX_CYCLES)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  assign cpu_rst   = (state_q != S_RUN);
  assign done      = (state_q == S_DONE);
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;
  assign result    = result_q;

`ifdef CPU_RUN_CTRL_TRACE_EN
  logic [31:0] trace_q [16];
  logic [31:0] trace_d [16];
  logic [3:0]  wptr_q, wptr_d;

  always_comb begin
    trace_d = trace_q;
    wptr_d  = wptr_q;
    if (trace_clr) begin
      for (int unsigned i = 0; i < 16; i++) trace_d[i] = '0;
      wptr_d = '0;
    end else if (trace_we) begin
      trace_d[wptr_q] = pc;
      wptr_d          = wptr_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++) trace_q[i] <= '0;
      wptr_q <= '0;
    end else begin
      trace_q <= trace_d;
      wptr_q  <= wptr_d;
    end
  end

  // 4-bit arithmetic gives the modulo-16 wrap for free.
  assign trace_pc = trace_q[wptr_q - 4'd1 - trace_idx];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, trace_we, trace_clr};
  assign trace_pc     = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned RST_C = 2;
  localparam int unsigned HALT_C = 3;
  localparam int unsigned MAX_C = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc, nxtPC, alures;
  logic        cpu_rst, done, timeout;
  logic [31:0] cycle_cnt, result;
  logic [3:0]  trace_idx;
  logic [31:0] trace_pc;

  cpu_run_ctrl #(.RST_CYCLES(RST_C), .HALT_REPEAT(HALT_C), .MAX_CYCLES(MAX_C)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .nxtPC(nxtPC), .alures(alures),
    .cpu_rst(cpu_rst), .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .result(result), .trace_idx(trace_idx), .trace_pc(trace_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        to;
    logic [31:0] res;
    logic [31:0] cnt;
    int unsigned runlen;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a rising done is the DUT presenting a completed run.
  logic        done_prev = 1'b0;
  int unsigned run_seen  = 0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".timeout"}, {31'd0, timeout}, {31'd0, e.to});
        check({e.name, ".result"}, result, e.res);
        check({e.name, ".cycle_cnt"}, cycle_cnt, e.cnt);
        check({e.name, ".run_cycles"}, run_seen, e.runlen);
      end
    end
    if (cpu_rst === 1'b0)      run_seen++;
    else if (done !== 1'b1)    run_seen = 0;
    done_prev = done;
  end

  task automatic cyc(input logic [31:0] p, input logic [31:0] n, input logic [31:0] a);
    pc = p; nxtPC = n; alures = a;
    @(negedge clk);
  endtask

  // Pulse start and measure how many cycles cpu_rst stays high in HOLD.
  task automatic do_start(input string name);
    int unsigned hold;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold = 0;
    while (cpu_rst === 1'b1 && hold < 10) begin
      hold++;
      @(negedge clk);
    end
    check({name, ".hold_cycles"}, hold, RST_C);
  endtask

  initial begin
    int unsigned bad;
    exp_t e;
    rst = 1'b0; start = 1'b0; pc = '0; nxtPC = '0; alures = '0; trace_idx = '0;

    // Reset state
    #2;
    check("reset.cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.timeout", {31'd0, timeout}, 32'd0);
    check("reset.cycle_cnt", cycle_cnt, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.trace_pc", trace_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle without start: CPU stays in reset, no completion
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      pc = 32'(i * 4); nxtPC = pc;
      @(negedge clk);
      if (cpu_rst !== 1'b1 || done !== 1'b0) bad++;
    end
    check("idle.held_cycles_bad", bad, 32'd0);

    // Halt run: 10 advancing cycles then 3 self-loop cycles at 0x40
    e = '{"halt", 1'b0, 32'h2A, 32'd13, 13};
    sb.push_back(e);
    do_start("halt");
    for (int i = 0; i < 10; i++) cyc(32'(i * 4), 32'(i * 4 + 4), 32'h11);
    cyc(32'h40, 32'h40, 32'h2A);
    cyc(32'h40, 32'h40, 32'h2A);
    check("halt.done_before_3rd", {31'd0, done}, 32'd0);
    cyc(32'h40, 32'h40, 32'h2A);
    // DONE holds while inputs keep changing
    cyc(32'h99, 32'h99, 32'h1234);
    cyc(32'h98, 32'h98, 32'h5678);
    check("halt.hold_done", {31'd0, done}, 32'd1);
    check("halt.hold_cycle_cnt", cycle_cnt, 32'd13);
    check("halt.hold_result", result, 32'h2A);
    check("halt.hold_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Timeout run, start pulsed mid-run must be ignored; result cleared
    e = '{"timeout", 1'b1, 32'h0, 32'd20, 20};
    sb.push_back(e);
    do_start("timeout");
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      cyc(32'h100 + 32'(i * 4), 32'h104 + 32'(i * 4), 32'(i + 1));
    end
    start = 1'b0;
    cyc(32'h0, 32'h0, 32'h0);
    check("timeout.hold_timeout", {31'd0, timeout}, 32'd1);

    // Halt on the budget cycle; an interrupted repeat streak must clear
    e = '{"tie", 1'b0, 32'h55, 32'd20, 20};
    sb.push_back(e);
    do_start("tie");
    for (int i = 0; i < 14; i++) cyc(32'(i * 8), 32'(i * 8 + 8), 32'h1);
    cyc(32'h80, 32'h80, 32'h2);
    cyc(32'h80, 32'h80, 32'h3);
    cyc(32'h80, 32'h84, 32'h4);
    cyc(32'h300, 32'h300, 32'h55);
    cyc(32'h300, 32'h300, 32'h55);
    cyc(32'h300, 32'h300, 32'h55);

    // Trace run: 20 cycles over pc = 0,4,...,76 (ends by timeout)
    e = '{"trace", 1'b1, 32'h0, 32'd20, 20};
    sb.push_back(e);
    do_start("trace");
    for (int i = 0; i < 20; i++) cyc(32'(i * 4), 32'(i * 4 + 4), 32'h7);
    trace_idx = 4'd0;
    #1;
`ifdef CPU_RUN_CTRL_TRACE_EN
    check("trace.idx0", trace_pc, 32'd76);
    trace_idx = 4'd15; #1;
    check("trace.idx15", trace_pc, 32'd16);
    trace_idx = 4'd5; #1;
    check("trace.idx5", trace_pc, 32'd56);
`else
    check("trace.idx0_tied", trace_pc, 32'd0);
    trace_idx = 4'd15; #1;
    check("trace.idx15_tied", trace_pc, 32'd0);
`endif
    trace_idx = 4'd0;
    @(negedge clk);

    // Reset mid-run: immediate IDLE, no resume, full HOLD on restart
    do_start("midrst");
    for (int i = 0; i < 5; i++) cyc(32'(i * 4), 32'(i * 4 + 4), 32'h9);
    #2 rst = 1'b0;
    #1;
    check("midrst.cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst.cycle_cnt", cycle_cnt, 32'd0);
    check("midrst.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(32'h200, 32'h200, 32'h66);
      if (cpu_rst !== 1'b1) bad++;
    end
    check("midrst.no_resume_bad", bad, 32'd0);
    e = '{"rerun", 1'b0, 32'h77, 32'd3, 3};
    sb.push_back(e);
    do_start("rerun");
    cyc(32'h200, 32'h200, 32'h77);
    cyc(32'h200, 32'h200, 32'h77);
    cyc(32'h200, 32'h200, 32'h77);
    cyc(32'h0, 32'h0, 32'h0);

    check("scoreboard.pending", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
